// File: rtl/anycore_encoder_pkg.sv
// Shared definitions for the Anycore response encoder: tracker state
// encoding, L1.5 request/return type codes and the 64-bit byte flip.
package anycore_encoder_pkg;

    // Tracker state encoding, kept as plain constants for legacy users.
    localparam logic [0:0] TRK_IDLE    = 1'b0;
    localparam logic [0:0] TRK_PENDING = 1'b1;

    // Request types (decoder -> L1.5)
    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [4:0] IMISS_RQ = 5'b10000;

    // Return types (L1.5 -> transducer)
    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] ST_ACK    = 4'b0100;

    // Outstanding-request class selected by a request or return type.
    typedef enum logic [1:0] {
        CLS_IMISS = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2,
        CLS_NONE  = 2'd3
    } trk_class_e;

    // Byte reversal of one 64-bit word (byte 0 <-> byte 7) to Anycore order.
    function automatic logic [63:0] flip64(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/anycore_encoder_tracker.sv
// One outstanding-request tracker: captures an address on request accept,
// emits a one-cycle registered strobe with that address on the response.
module anycore_encoder_tracker
    import anycore_encoder_pkg::*;
#(
    parameter int unsigned AW = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture_i,
    input  logic [AW-1:0] cap_addr_i,
    input  logic          respond_i,
    output logic          complete_o,
    output logic          strobe_o,
    output logic [AW-1:0] resp_addr_o,
    output logic          err_o
);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          strobe_q, strobe_d;
    logic [AW-1:0] resp_addr_q, resp_addr_d;

    // Response is resolved against the current state before a same-cycle
    // capture, so a simultaneous capture re-arms with the new address.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        strobe_d    = 1'b0;
        resp_addr_d = resp_addr_q;
        complete_o  = 1'b0;
        err_o       = 1'b0;
        if (respond_i) begin
            if (state_q == TRK_PENDING) begin
                complete_o  = 1'b1;
                strobe_d    = 1'b1;
                resp_addr_d = addr_q;
                state_d     = TRK_IDLE;
            end else begin
                err_o = 1'b1;
            end
        end
        if (capture_i) begin
            if (state_d == TRK_PENDING) begin
                err_o = 1'b1;
            end
            state_d = TRK_PENDING;
            addr_d  = cap_addr_i;
        end
    end

    // Tracker state, stored address and registered strobe/address outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= TRK_IDLE;
            addr_q      <= '0;
            strobe_q    <= 1'b0;
            resp_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            strobe_q    <= strobe_d;
            resp_addr_q <= resp_addr_d;
        end
    end

    assign strobe_o    = strobe_q;
    assign resp_addr_o = resp_addr_q;

endmodule

// File: rtl/anycore_encoder.sv
// Anycore response encoder: turns L1.5 return packets into icache fill,
// dcache load-fill and store-complete strobes using three trackers.
module anycore_encoder
    import anycore_encoder_pkg::*;
#(
    parameter int unsigned PHY_ADDR_WIDTH = 40,
    parameter int unsigned IC_FILL_BITS   = 256,
    parameter int unsigned DC_FILL_BITS   = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      l15_transducer_header_ack,
    input  logic [4:0]                anycoredecoder_l15_rqtype,
    input  logic [PHY_ADDR_WIDTH-1:0] anycoredecoder_l15_address,
    input  logic                      l15_transducer_val,
    input  logic [3:0]                l15_transducer_returntype,
    input  logic [63:0]               l15_transducer_data_0,
    input  logic [63:0]               l15_transducer_data_1,
    input  logic [63:0]               l15_transducer_data_2,
    input  logic [63:0]               l15_transducer_data_3,
    output logic                      transducer_l15_req_ack,
    output logic                      anycore_mem2ic_respvalid,
    output logic [PHY_ADDR_WIDTH-1:0] anycore_mem2ic_respaddr,
    output logic [IC_FILL_BITS-1:0]   anycore_mem2ic_data,
    output logic                      anycore_mem2dc_ldvalid,
    output logic [PHY_ADDR_WIDTH-1:0] anycore_mem2dc_ldaddr,
    output logic [DC_FILL_BITS-1:0]   anycore_mem2dc_lddata,
    output logic                      anycore_mem2dc_stcomplete,
    output logic [PHY_ADDR_WIDTH-1:0] anycore_mem2dc_staddr,
    output logic                      encoder_err
);

    trk_class_e cap_cls, rsp_cls;
    logic [2:0] capture, respond, complete, err;
    logic       ack_q;
    logic       err_q;
    logic [IC_FILL_BITS-1:0] ic_data_q;
    logic [DC_FILL_BITS-1:0] dc_data_q;

    // Map accepted request and valid response onto a tracker class.
    always_comb begin
        cap_cls = CLS_NONE;
        rsp_cls = CLS_NONE;
        if (l15_transducer_header_ack) begin
            case (anycoredecoder_l15_rqtype)
                IMISS_RQ: cap_cls = CLS_IMISS;
                LOAD_RQ:  cap_cls = CLS_LOAD;
                STORE_RQ: cap_cls = CLS_STORE;
                default:  cap_cls = CLS_NONE;
            endcase
        end
        if (l15_transducer_val) begin
            case (l15_transducer_returntype)
                IFILL_RET: rsp_cls = CLS_IMISS;
                LOAD_RET:  rsp_cls = CLS_LOAD;
                ST_ACK:    rsp_cls = CLS_STORE;
                default:   rsp_cls = CLS_NONE;
            endcase
        end
        capture = {cap_cls == CLS_STORE, cap_cls == CLS_LOAD, cap_cls == CLS_IMISS};
        respond = {rsp_cls == CLS_STORE, rsp_cls == CLS_LOAD, rsp_cls == CLS_IMISS};
    end

    anycore_encoder_tracker #(.AW(PHY_ADDR_WIDTH)) u_trk_imiss (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture_i   (capture[0]),
        .cap_addr_i  (anycoredecoder_l15_address),
        .respond_i   (respond[0]),
        .complete_o  (complete[0]),
        .strobe_o    (anycore_mem2ic_respvalid),
        .resp_addr_o (anycore_mem2ic_respaddr),
        .err_o       (err[0])
    );

    anycore_encoder_tracker #(.AW(PHY_ADDR_WIDTH)) u_trk_load (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture_i   (capture[1]),
        .cap_addr_i  (anycoredecoder_l15_address),
        .respond_i   (respond[1]),
        .complete_o  (complete[1]),
        .strobe_o    (anycore_mem2dc_ldvalid),
        .resp_addr_o (anycore_mem2dc_ldaddr),
        .err_o       (err[1])
    );

    anycore_encoder_tracker #(.AW(PHY_ADDR_WIDTH)) u_trk_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture_i   (capture[2]),
        .cap_addr_i  (anycoredecoder_l15_address),
        .respond_i   (respond[2]),
        .complete_o  (complete[2]),
        .strobe_o    (anycore_mem2dc_stcomplete),
        .resp_addr_o (anycore_mem2dc_staddr),
        .err_o       (err[2])
    );

    // Response ack, sticky error and fill data held until the next fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ic_data_q <= '0;
            dc_data_q <= '0;
        end else begin
            ack_q <= l15_transducer_val;
            if (|err) begin
                err_q <= 1'b1;
            end
            if (complete[0]) begin
                ic_data_q <= IC_FILL_BITS'({flip64(l15_transducer_data_3),
                                            flip64(l15_transducer_data_2),
                                            flip64(l15_transducer_data_1),
                                            flip64(l15_transducer_data_0)});
            end
            if (complete[1]) begin
                dc_data_q <= DC_FILL_BITS'({flip64(l15_transducer_data_1),
                                            flip64(l15_transducer_data_0)});
            end
        end
    end

    assign transducer_l15_req_ack = ack_q;
    assign encoder_err            = err_q;
    assign anycore_mem2ic_data    = ic_data_q;
    assign anycore_mem2dc_lddata  = dc_data_q;

endmodule

// File: tb/tb_anycore_encoder.sv
// Directed self-checking bench for anycore_encoder with a one-step
// scoreboard fed by an independent behavioural model.
module tb_anycore_encoder;

    localparam logic [4:0] T_LOAD_RQ   = 5'b00000;
    localparam logic [4:0] T_STORE_RQ  = 5'b00001;
    localparam logic [4:0] T_IMISS_RQ  = 5'b10000;
    localparam logic [4:0] T_OTHER_RQ  = 5'b00110;
    localparam logic [3:0] T_LOAD_RET  = 4'b0000;
    localparam logic [3:0] T_IFILL_RET = 4'b0001;
    localparam logic [3:0] T_ST_ACK    = 4'b0100;
    localparam logic [3:0] T_INT_RET   = 4'b0111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hack;
    logic [4:0]    rqtype;
    logic [39:0]   rqaddr;
    logic          val;
    logic [3:0]    rtype;
    logic [63:0]   d0, d1, d2, d3;
    logic          req_ack;
    logic          ic_v, ld_v, st_v, err;
    logic [39:0]   ic_addr, ld_addr, st_addr;
    logic [255:0]  ic_data;
    logic [127:0]  ld_data;

    typedef struct packed {
        logic         ack;
        logic         ic_v;
        logic [39:0]  ic_addr;
        logic [255:0] ic_data;
        logic         ld_v;
        logic [39:0]  ld_addr;
        logic [127:0] ld_data;
        logic         st_v;
        logic [39:0]  st_addr;
        logic         err;
    } exp_t;

    exp_t        sb[$];
    exp_t        held;
    logic        pend [3];
    logic [39:0] maddr [3];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    anycore_encoder #(
        .PHY_ADDR_WIDTH (40),
        .IC_FILL_BITS   (256),
        .DC_FILL_BITS   (128)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .l15_transducer_header_ack  (hack),
        .anycoredecoder_l15_rqtype  (rqtype),
        .anycoredecoder_l15_address (rqaddr),
        .l15_transducer_val         (val),
        .l15_transducer_returntype  (rtype),
        .l15_transducer_data_0      (d0),
        .l15_transducer_data_1      (d1),
        .l15_transducer_data_2      (d2),
        .l15_transducer_data_3      (d3),
        .transducer_l15_req_ack     (req_ack),
        .anycore_mem2ic_respvalid   (ic_v),
        .anycore_mem2ic_respaddr    (ic_addr),
        .anycore_mem2ic_data        (ic_data),
        .anycore_mem2dc_ldvalid     (ld_v),
        .anycore_mem2dc_ldaddr      (ld_addr),
        .anycore_mem2dc_lddata      (ld_data),
        .anycore_mem2dc_stcomplete  (st_v),
        .anycore_mem2dc_staddr      (st_addr),
        .encoder_err                (err)
    );

    function automatic logic [63:0] bswap(input logic [63:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24],
                w[39:32], w[47:40], w[55:48], w[63:56]};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Wait for the registered response of this step, then compare against the oldest expectation.
    task automatic observe(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".ack"},     256'(req_ack), 256'(e.ack));
            chk({tag, ".ic_v"},    256'(ic_v),    256'(e.ic_v));
            chk({tag, ".ic_addr"}, 256'(ic_addr), 256'(e.ic_addr));
            chk({tag, ".ic_data"}, ic_data,       e.ic_data);
            chk({tag, ".ld_v"},    256'(ld_v),    256'(e.ld_v));
            chk({tag, ".ld_addr"}, 256'(ld_addr), 256'(e.ld_addr));
            chk({tag, ".ld_data"}, 256'(ld_data), 256'(e.ld_data));
            chk({tag, ".st_v"},    256'(st_v),    256'(e.st_v));
            chk({tag, ".st_addr"}, 256'(st_addr), 256'(e.st_addr));
            chk({tag, ".err"},     256'(err),     256'(e.err));
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        hack = 1'b0; rqtype = '0; rqaddr = '0;
        val = 1'b0;  rtype = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        for (int i = 0; i < 3; i++) begin
            pend[i]  = 1'b0;
            maddr[i] = '0;
        end
        held = '0;
        sb.push_back(held);
        observe(tag);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of stimulus and push the model's expected outputs.
    task automatic step(input string tag,
                        input logic h, input logic [4:0] rq, input logic [39:0] ra,
                        input logic v, input logic [3:0] rt,
                        input logic [63:0] w0, input logic [63:0] w1,
                        input logic [63:0] w2, input logic [63:0] w3);
        exp_t e;
        int   c;
        hack = h; rqtype = rq; rqaddr = ra;
        val = v;  rtype = rt;
        d0 = w0; d1 = w1; d2 = w2; d3 = w3;

        e = held;
        e.ack = v; e.ic_v = 1'b0; e.ld_v = 1'b0; e.st_v = 1'b0;
        c = -1;
        if (v) begin
            if (rt == T_IFILL_RET)     c = 0;
            else if (rt == T_LOAD_RET) c = 1;
            else if (rt == T_ST_ACK)   c = 2;
        end
        if (c >= 0) begin
            if (pend[c]) begin
                pend[c] = 1'b0;
                if (c == 0) begin
                    e.ic_v = 1'b1; e.ic_addr = maddr[0];
                    e.ic_data = {bswap(w3), bswap(w2), bswap(w1), bswap(w0)};
                end else if (c == 1) begin
                    e.ld_v = 1'b1; e.ld_addr = maddr[1];
                    e.ld_data = {bswap(w1), bswap(w0)};
                end else begin
                    e.st_v = 1'b1; e.st_addr = maddr[2];
                end
            end else begin
                e.err = 1'b1;
            end
        end
        c = -1;
        if (h) begin
            if (rq == T_IMISS_RQ)      c = 0;
            else if (rq == T_LOAD_RQ)  c = 1;
            else if (rq == T_STORE_RQ) c = 2;
        end
        if (c >= 0) begin
            if (pend[c]) e.err = 1'b1;
            pend[c]  = 1'b1;
            maddr[c] = ra;
        end
        held = e;
        held.ack = 1'b0; held.ic_v = 1'b0; held.ld_v = 1'b0; held.st_v = 1'b0;
        sb.push_back(e);
        observe(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [63:0] r0, r1;
        r0 = {$urandom, $urandom};
        r1 = {$urandom, $urandom};

        do_reset("reset");

        // Instruction fill
        step("imiss_cap", 1'b1, T_IMISS_RQ, 40'h00_0000_1000, 1'b0, '0, '0, '0, '0, '0);
        step("ifill", 1'b0, '0, '0, 1'b1, T_IFILL_RET,
             64'h0102030405060708, 64'h1112131415161718,
             64'h2122232425262728, 64'h3132333435363738);
        idle("ifill_hold");

        // Load fill
        step("load_cap", 1'b1, T_LOAD_RQ, 40'h80, 1'b0, '0, '0, '0, '0, '0);
        step("load_ret", 1'b0, '0, '0, 1'b1, T_LOAD_RET, r0, r1, 64'hdead, 64'hbeef);
        idle("load_hold");

        // Store ack
        step("store_cap", 1'b1, T_STORE_RQ, 40'h48, 1'b0, '0, '0, '0, '0, '0);
        step("st_ack", 1'b0, '0, '0, 1'b1, T_ST_ACK, '0, '0, '0, '0);
        idle("st_hold");

        // Non-tracked return type: ack only
        step("int_ret", 1'b0, '0, '0, 1'b1, T_INT_RET, 64'h55, '0, '0, '0);
        idle("int_hold");

        // Unmatched store ack raises sticky error
        step("st_orphan", 1'b0, '0, '0, 1'b1, T_ST_ACK, '0, '0, '0, '0);
        idle("err_sticky1");
        idle("err_sticky2");

        // Simultaneous load response and capture
        do_reset("reset2");
        step("ld_cap80", 1'b1, T_LOAD_RQ, 40'h80, 1'b0, '0, '0, '0, '0, '0);
        step("ld_ret_capC0", 1'b1, T_LOAD_RQ, 40'hC0, 1'b1, T_LOAD_RET,
             64'h0011223344556677, 64'h8899aabbccddeeff, '0, '0);
        idle("ld_gap");
        step("ld_retC0", 1'b0, '0, '0, 1'b1, T_LOAD_RET, r1, r0, '0, '0);
        idle("ld_gap2");

        // Ignored request type leaves load tracker idle
        step("other_rq", 1'b1, T_OTHER_RQ, 40'h200, 1'b0, '0, '0, '0, '0, '0);
        step("ld_orphan", 1'b0, '0, '0, 1'b1, T_LOAD_RET, r0, r0, '0, '0);
        idle("ld_orphan_hold");

        // Capture over a pending tracker overwrites address and errors
        do_reset("reset3");
        step("im_cap2000", 1'b1, T_IMISS_RQ, 40'h2000, 1'b0, '0, '0, '0, '0, '0);
        step("im_cap3000", 1'b1, T_IMISS_RQ, 40'h3000, 1'b0, '0, '0, '0, '0, '0);
        step("ifill3000", 1'b0, '0, '0, 1'b1, T_IFILL_RET, r0, r1, r1, r0);
        idle("ifill3000_hold");

        // Reset discards pending imiss
        do_reset("reset4");
        step("im_cap4000", 1'b1, T_IMISS_RQ, 40'h4000, 1'b0, '0, '0, '0, '0, '0);
        do_reset("reset5");
        step("ifill_after_rst", 1'b0, '0, '0, 1'b1, T_IFILL_RET, r0, r0, r0, r0);
        idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
